// File: rtl/stall_ctrl.sv
// stall_ctrl: turns hazard/branch/halt requests from decode into PC, IF/ID and ID/EX
// enables and bubble controls, with a saturating stall counter and halt drain sequencing.
module stall_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             haz_req,
    input  logic [1:0]       haz_dist,
    input  logic             br_taken,
    input  logic             halt_req,
    output logic             pc_wr_en,
    output logic             if_id_wr_en,
    output logic             if_id_flush,
    output logic             id_ex_nop,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;
    state_t           state_q, state_d;
    logic [1:0]       bub_q, bub_d;
    logic [2:0]       drain_q, drain_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             haz, haz_bub, halt_go, wr;
    always_comb begin
        haz      = haz_req && haz_dist != 2'd0;
        haz_bub  = (state_q == RUN && haz) || state_q == STALL;
        halt_go  = state_q == RUN && !haz && halt_req;
        wr       = state_q == RUN && !haz && !halt_req;
        state_d  = state_q;
        bub_d    = bub_q;
        drain_d  = drain_q;
        if (state_q == RUN) begin
            if (haz && haz_dist > 2'd1) begin
                state_d = STALL;
                bub_d   = haz_dist - 2'd1;
            end else if (halt_go) begin
                state_d = DRAIN;
                drain_d = 3'(DRAIN_CYC);
            end
        end else if (state_q == STALL) begin
            bub_d   = bub_q - 2'd1;
            state_d = bub_q == 2'd1 ? RUN : STALL;
        end else if (state_q == DRAIN) begin
            drain_d = drain_q - 3'd1;
            state_d = drain_q == 3'd1 ? HALTED : DRAIN;
        end
        halted_d = halted_q || (state_q == DRAIN && drain_q == 3'd1);
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, haz_bub && cnt_q != '1};
    end
    // reset overrides the Mealy outputs asynchronously, not just the state
    assign pc_wr_en     = !rst && wr;
    assign if_id_wr_en  = !rst && wr;
    assign if_id_flush  = rst || (wr && br_taken);
    assign id_ex_nop    = rst || haz_bub || state_q == DRAIN || state_q == HALTED;
    assign halted       = halted_q;
    assign stall_cycles = cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            bub_q    <= 2'd0;
            drain_q  <= 3'd0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            bub_q    <= bub_d;
            drain_q  <= drain_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed stimulus with a cycle-count model checked every negedge plus literal checks.
module tb_stall_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       haz_req = 1'b0;
    logic [1:0] haz_dist = 2'd0;
    logic       br_taken = 1'b0;
    logic       halt_req = 1'b0;
    logic       pc_wr_en, if_id_wr_en, if_id_flush, id_ex_nop, halted;
    logic [3:0] stall_cycles;
    int         checks = 0;
    int         errors = 0;
    int         nop_cnt = 0;
    int         n0;
    int         m_bub = 0;
    int         m_drain = 0;
    int         m_st = 0;
    bit         m_hlt = 0;
    logic       e_pc, e_fl, e_nop;

    stall_ctrl #(.CNT_W(4), .DRAIN_CYC(3)) dut (
        .clk(clk), .rst(rst), .haz_req(haz_req), .haz_dist(haz_dist),
        .br_taken(br_taken), .halt_req(halt_req), .pc_wr_en(pc_wr_en),
        .if_id_wr_en(if_id_wr_en), .if_id_flush(if_id_flush),
        .id_ex_nop(id_ex_nop), .halted(halted), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model counts remaining forced bubble / drain cycles; registered outputs show pre-edge values.
    always @(negedge clk) begin
        if (rst) begin
            {e_pc, e_fl, e_nop} = 3'b011;
            chk("m_halted", {31'b0, halted}, 0);
            chk("m_stalls", {28'b0, stall_cycles}, 0);
            m_bub = 0; m_drain = 0; m_st = 0; m_hlt = 0;
        end else begin
            chk("m_halted", {31'b0, halted}, {31'b0, m_hlt});
            chk("m_stalls", {28'b0, stall_cycles}, m_st);
            if (id_ex_nop) nop_cnt++;
            if (m_hlt) {e_pc, e_fl, e_nop} = 3'b001;
            else if (m_drain > 0) begin
                {e_pc, e_fl, e_nop} = 3'b001;
                m_drain--;
                if (m_drain == 0) m_hlt = 1;
            end else if (m_bub > 0) begin
                {e_pc, e_fl, e_nop} = 3'b001;
                m_bub--;
                m_st = m_st == 15 ? 15 : m_st + 1;
            end else if (haz_req && haz_dist != 0) begin
                {e_pc, e_fl, e_nop} = 3'b001;
                m_bub = int'(haz_dist) - 1;
                m_st = m_st == 15 ? 15 : m_st + 1;
            end else if (halt_req) begin
                {e_pc, e_fl, e_nop} = 3'b000;
                m_drain = 3;
            end else {e_pc, e_fl, e_nop} = {1'b1, br_taken, 1'b0};
        end
        chk("m_pc_wr_en", {31'b0, pc_wr_en}, {31'b0, e_pc});
        chk("m_if_id_wr_en", {31'b0, if_id_wr_en}, {31'b0, rst ? 1'b0 : e_pc});
        chk("m_if_id_flush", {31'b0, if_id_flush}, {31'b0, e_fl});
        chk("m_id_ex_nop", {31'b0, id_ex_nop}, {31'b0, e_nop});
    end

    task automatic drive(input logic h, input logic [1:0] d, input logic b, input logic t);
        haz_req = h; haz_dist = d; br_taken = b; halt_req = t;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic h, input logic [1:0] d, input logic b, input logic t);
        drive(h, d, b, t);
        tick();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 0, 0, 0);
        chk("idle_pc", {31'b0, pc_wr_en}, 1);
        chk("idle_nop", {31'b0, id_ex_nop}, 0);
        chk("idle_flush", {31'b0, if_id_flush}, 0);
        chk("idle_stalls", {28'b0, stall_cycles}, 0);
        tick();
        n0 = nop_cnt;
        step(1, 3, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        chk("dist3_bubbles", nop_cnt - n0, 3);
        chk("dist3_stalls", {28'b0, stall_cycles}, 3);
        n0 = nop_cnt;
        step(1, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        chk("dist1_bubbles", nop_cnt - n0, 1);
        n0 = nop_cnt;
        step(1, 2, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        chk("dist2_bubbles", nop_cnt - n0, 2);
        chk("dist2_stalls", {28'b0, stall_cycles}, 6);
        drive(1, 0, 1, 0);
        chk("dist0_pc", {31'b0, pc_wr_en}, 1);
        chk("dist0_flush", {31'b0, if_id_flush}, 1);
        tick();
        n0 = nop_cnt;
        drive(1, 2, 1, 0);
        chk("hazbr_flush", {31'b0, if_id_flush}, 0);
        chk("hazbr_nop", {31'b0, id_ex_nop}, 1);
        tick();
        drive(1, 3, 1, 0);
        chk("stall_ign_flush", {31'b0, if_id_flush}, 0);
        chk("stall_ign_pc", {31'b0, pc_wr_en}, 0);
        tick();
        drive(0, 0, 1, 0);
        chk("br_after_flush", {31'b0, if_id_flush}, 1);
        chk("br_after_pc", {31'b0, pc_wr_en}, 1);
        chk("br_after_nop", {31'b0, id_ex_nop}, 0);
        tick();
        chk("hazbr_bubbles", nop_cnt - n0, 2);
        chk("hazbr_stalls", {28'b0, stall_cycles}, 8);
        repeat (20) step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("sat_stalls", {28'b0, stall_cycles}, 15);
        step(1, 3, 0, 0);
        haz_req = 1'b0; haz_dist = 2'd0;
        #1 rst = 1'b1;
        #1;
        chk("rst_pc", {31'b0, pc_wr_en}, 0);
        chk("rst_ifid", {31'b0, if_id_wr_en}, 0);
        chk("rst_flush", {31'b0, if_id_flush}, 1);
        chk("rst_nop", {31'b0, id_ex_nop}, 1);
        chk("rst_stalls", {28'b0, stall_cycles}, 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        chk("post_rst_pc", {31'b0, pc_wr_en}, 1);
        chk("post_rst_nop", {31'b0, id_ex_nop}, 0);
        tick();
        drive(0, 0, 0, 1);
        chk("halt_hold_pc", {31'b0, pc_wr_en}, 0);
        chk("halt_hold_nop", {31'b0, id_ex_nop}, 0);
        chk("halt_hold_flush", {31'b0, if_id_flush}, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 3, 1, 1);
            chk("drain_nop", {31'b0, id_ex_nop}, 1);
            chk("drain_pc", {31'b0, pc_wr_en}, 0);
            chk("drain_halted", {31'b0, halted}, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 2, 1, 0);
            chk("halted_set", {31'b0, halted}, 1);
            chk("halted_nop", {31'b0, id_ex_nop}, 1);
            chk("halted_pc", {31'b0, pc_wr_en}, 0);
            tick();
        end
        chk("halt_stalls", {28'b0, stall_cycles}, 0);
        drive(0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
